// File: rtl/mdio_read_sequencer_if.sv
// Host-side word handshake for the MDIO read sequencer.
// Ports: out_data/out_valid (sequencer to host), out_ready (host to sequencer).
interface mdio_read_sequencer_if;
    logic [8:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mdio_read_sequencer.sv
// Sweeps MDIO capture-memory lanes across an address window and hands each word to the host.
// Ports: clk/rstn, start/abort/cfg_* control, rf_mdio_* read path, out_if handshake, busy/done/cfg_err/word_cnt status.
module mdio_read_sequencer #(
    parameter int RD_LAT = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic        cfg_96path_en,
    input  logic [14:0] cfg_addr_start,
    input  logic [14:0] cfg_addr_end,
    output logic        mdio_read_en,
    output logic        rf_mdio_read_pulse,
    output logic [6:0]  rf_mdio_data_sel,
    output logic [14:0] rf_mdio_memory_addr,
    input  logic [8:0]  rf_mdio_pkt_data,
    mdio_read_sequencer_if.master out_if,
    output logic        busy,
    output logic        done,
    output logic        cfg_err,
    output logic [21:0] word_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        NEXT,
        DONE
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  lat_q, lat_d;
    logic [6:0]  sel_q, sel_d;
    logic [6:0]  last_q, last_d;
    logic [14:0] addr_q, addr_d;
    logic [14:0] a_start_q, a_start_d;
    logic [14:0] a_end_q, a_end_d;
    logic [8:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [21:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cfg_ok;

    assign cfg_ok = (cfg_addr_end >= cfg_addr_start);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            lat_q     <= '0;
            sel_q     <= '0;
            last_q    <= '0;
            addr_q    <= '0;
            a_start_q <= '0;
            a_end_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            a_start_q <= a_start_d;
            a_end_q   <= a_end_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        sel_d     = sel_q;
        last_d    = last_q;
        addr_d    = addr_q;
        a_start_d = a_start_q;
        a_end_d   = a_end_q;
        data_d    = data_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = 1'b0;

        if (abort) begin
            // word_cnt survives an abort so the host can see progress
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            last_d    = cfg_96path_en ? 7'd95 : 7'd47;
                            a_start_d = cfg_addr_start;
                            a_end_d   = cfg_addr_end;
                            sel_d     = '0;
                            addr_d    = cfg_addr_start;
                            cnt_d     = '0;
                            done_d    = 1'b0;
                            state_d   = ISSUE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    lat_d   = LAT_LOAD;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (lat_q == 4'd0) begin
                        data_d  = rf_mdio_pkt_data;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        lat_d = lat_q - 4'd1;
                    end
                end
                HOLD: begin
                    if (out_if.out_ready) begin
                        valid_d = 1'b0;
                        cnt_d   = cnt_q + 22'd1;
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    // compare before increment: an end of 0x7FFF never wraps
                    if (addr_q != a_end_q) begin
                        addr_d  = addr_q + 15'd1;
                        state_d = ISSUE;
                    end else if (sel_q != last_q) begin
                        sel_d   = sel_q + 7'd1;
                        addr_d  = a_start_q;
                        state_d = ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy                = (state_q != IDLE) && (state_q != DONE);
    assign mdio_read_en        = busy;
    assign rf_mdio_read_pulse  = (state_q == ISSUE);
    assign rf_mdio_data_sel    = sel_q;
    assign rf_mdio_memory_addr = addr_q;
    assign out_if.out_data     = data_q;
    assign out_if.out_valid    = valid_q;
    assign done                = done_q;
    assign cfg_err             = err_q;
    assign word_cnt            = cnt_q;

endmodule

// File: doc/mdio_read_sequencer.md
# mdio_read_sequencer

Autonomous sweep controller for the MDIO capture-memory read path in `pktctrl`. On a host start command it walks every selected 9-bit lane (`data_sel` 0..47 or 0..95) across a programmable address window. For each word it drives the read-path controls (`mdio_read_en`, `rf_mdio_read_pulse`, `rf_mdio_data_sel`, `rf_mdio_memory_addr`), waits the fixed read latency, captures `rf_mdio_pkt_data`, and presents it to the MDIO register front-end over a valid/ready handshake.

## Interface
- `RD_LAT`, 3: cycles from `rf_mdio_read_pulse` to `rf_mdio_pkt_data` being valid; range 2..15.
- `clk`  in  1  single clock.
- `rstn`  in  1  synchronous active-low reset.
- `start`  in  1  pulse; begins a sweep; ignored unless state is IDLE or DONE.
- `abort`  in  1  pulse; ends the sweep; highest priority after reset.
- `cfg_96path_en`  in  1  1: lanes 0..95; 0: lanes 0..47. Latched at accepted start.
- `cfg_addr_start`  in  15  first memory address. Latched at accepted start.
- `cfg_addr_end`  in  15  last memory address, inclusive. Latched at accepted start.
- `mdio_read_en`  out  1  read path enable.
- `rf_mdio_read_pulse`  out  1  one-cycle read strobe.
- `rf_mdio_data_sel`  out  7  current lane.
- `rf_mdio_memory_addr`  out  15  current address.
- `rf_mdio_pkt_data`  in  9  captured word from the read path.
- `out_data`  out  9  word presented to the host.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  host accepts the word.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  sticky; set by sweep completion; cleared by `start`, `abort` or reset.
- `cfg_err`  out  1  one-cycle pulse; start rejected because `cfg_addr_end` < `cfg_addr_start`.
- `word_cnt`  out  22  words handed off since the last accepted start.

## Operation
States: IDLE, ISSUE, WAIT, HOLD, NEXT, DONE.

- **IDLE / DONE + `start`**
  - If `cfg_addr_end` ≥ `cfg_addr_start`: latch the config, set sel=0, addr=`cfg_addr_start`, `word_cnt`=0, clear `done`, go to ISSUE.
  - Otherwise: pulse `cfg_err`, stay in the current state; `done` is unchanged.
- **ISSUE** (1 cycle): `rf_mdio_read_pulse`=1, go to WAIT with the latency counter = RD_LAT-1.
- **WAIT**: decrement the counter each cycle. When it reaches 0, load `out_data` ← `rf_mdio_pkt_data`, set `out_valid`=1, go to HOLD.
- **HOLD**: hold `out_data` and `out_valid`. On `out_valid && out_ready`: clear `out_valid`, increment `word_cnt`, go to NEXT.
- **NEXT** (1 cycle), sweep order is lane-outer, address-inner:
  - If addr ≠ end: addr+1.
  - Else if sel ≠ last (47 or 95): sel+1, addr=start.
  - Else: set `done`=1 and go to DONE. Otherwise go to ISSUE.
- **Control outputs:** `mdio_read_en`=1 in ISSUE, WAIT, HOLD and NEXT. `rf_mdio_data_sel` and `rf_mdio_memory_addr` are registered and stay stable from ISSUE through HOLD.
- **Abort:** from any state, the next state is IDLE. Clear `out_valid`, `rf_mdio_read_pulse`, `mdio_read_en` and `done`. `word_cnt` keeps its value.
- **Simultaneous events:**
  - `start` and `abort` in the same cycle: abort wins.
  - `start` while busy: no effect.
  - `out_ready` outside HOLD: ignored.
- **Address arithmetic:** 15-bit with no wrap. `cfg_addr_end`=0x7FFF is reached without overflow because the compare happens before the increment.
- **Word count:** total words = lanes × (end−start+1); maximum 96×32768 = 3,145,728, which fits in 22 bits.

## Timing
- **Reset values:** state IDLE; all outputs 0, including `rf_mdio_data_sel`, `rf_mdio_memory_addr`, `out_data` and `word_cnt`.
- **Start:** `start` in cycle T → ISSUE in T+1, with `rf_mdio_read_pulse`=1 in T+1.
- **Capture:** `rf_mdio_pkt_data` is sampled at the end of cycle T+1+RD_LAT. `out_valid` rises in T+2+RD_LAT.
- **Handshake:** the transfer completes in the cycle `out_ready`=1 while `out_valid`=1. The next ISSUE follows 2 cycles later (NEXT, then ISSUE).
- **Throughput:** zero-stall per-word period is RD_LAT+3 cycles (6 at the default).
- **Completion:** `done` rises in the cycle after NEXT of the last word; `busy` falls in the same cycle.
- **Reset mid-sweep:** all state is discarded on the next edge; no partial word is presented.

## Test plan
- **Single word:** `cfg_96path_en`=0, start=end=0x0010, `out_ready` tied 1 → one read pulse with sel 0 / addr 0x0010; `out_valid` in cycle T+5; 48 words total with sel 0..47; `word_cnt`=48; `done`=1.
- **Window sweep:** `cfg_96path_en`=1, start=0x7FFC, end=0x7FFF → 384 words; address order 7FFC..7FFF repeated per lane; no address wrap; final sel=95.
- **Backpressure:** `out_ready` low for 20 cycles in HOLD → `out_data` stable; no new read pulse; exactly one `word_cnt` increment when `out_ready` rises.
- **Abort:** abort asserted in WAIT of word 5 → IDLE next cycle; `out_valid`=0; `mdio_read_en`=0; `word_cnt`=5; `done`=0.
- **Config error and retrigger:** end=0x0003, start=0x0004 → `cfg_err` pulses once; state stays IDLE. `start` during busy → ignored and the sweep is unchanged. `start` and `abort` in the same cycle → IDLE.
- **Data integrity:** model returns {sel[1:0], addr[6:0]} after RD_LAT=2 and RD_LAT=15 → every `out_data` matches the expected value; per-word period is 5 and 18 cycles respectively.
